// File: rtl/data_sram_responder.sv
// Word-organised data RAM answering the CPU's M-stage data port.
// One request at a time, programmable wait-state latency, stall to hazard unit.
//
// Ports:
//   clk              rising-edge clock
//   rst              synchronous active-high reset
//   data_sram_en     request valid (held by CPU while stalled)
//   data_sram_wen    byte write enables, 4'b0000 = read
//   data_sram_addr   byte address, word index = addr[ADDR_W+1:2]
//   data_sram_wdata  lane-aligned write data
//   data_sram_rdata  registered response word (post-write word for writes)
//   data_sram_rvalid one-cycle response strobe
//   data_sram_stall  hold request in the pipeline until the response cycle
module data_sram_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        data_sram_rvalid,
    output logic        data_sram_stall
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_RESP
    } state_t;

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [3:0] CNT_INIT =
        (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_next;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] w_idx;
    logic [31:0]       r_rdata;
    logic [31:0]       r_mem [DEPTH];
    logic [31:0]       w_merged;
    logic [31:0]       w_load_word;
    logic              w_accept;
    logic              w_load;
    logic              w_stall;
    logic              w_unused_addr;

    assign w_idx = data_sram_addr[ADDR_W+1:2];
    assign w_unused_addr =
        ^{data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

    // Reset beats a simultaneous request: nothing is committed.
    assign w_accept = (r_state == S_IDLE) && data_sram_en && !rst;

    // Word as it will look after this cycle's write lanes land.
    always_comb begin
        w_merged = r_mem[w_idx];
        for (int i = 0; i < 4; i++) begin
            if (data_sram_wen[i]) begin
                w_merged[8*i +: 8] = data_sram_wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_stall    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (data_sram_en) begin
                    w_stall = 1'b1;
                    if (LATENCY == 1) begin
                        w_next = S_RESP;
                    end else begin
                        w_next     = S_BUSY;
                        w_cnt_next = CNT_INIT;
                    end
                end
            end
            S_BUSY: begin
                w_stall = 1'b1;
                if (r_cnt == 4'd0) begin
                    w_next = S_RESP;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            S_RESP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // With single-cycle latency the response is loaded on the accept
    // edge, so the freshly merged word is forwarded instead of the RAM.
    assign w_load = (w_next == S_RESP) && (r_state != S_RESP);
    assign w_load_word = (r_state == S_IDLE) ? w_merged : r_mem[r_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_rdata <= 32'd0;
            r_idx   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_idx <= w_idx;
            end
            if (w_load) begin
                r_rdata <= w_load_word;
            end
        end
    end

    // RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[w_idx] <= w_merged;
        end
    end

    assign data_sram_rdata  = r_rdata;
    assign data_sram_rvalid = (r_state == S_RESP);
    assign data_sram_stall  = w_stall;

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: three instances (LATENCY 1, 3, 4),
// scoreboard of expected response words checked on each rvalid.
module tb_data_sram_responder;

    logic        clk;
    logic        rst;
    logic        en       [3];
    logic [3:0]  wen_s    [3];
    logic [31:0] addr_s   [3];
    logic [31:0] wdata_s  [3];
    logic [31:0] rdata_s  [3];
    logic        rvalid_s [3];
    logic        stall_s  [3];

    logic [31:0] model [3][1024];
    logic [31:0] sb [$];
    int          n_checks;
    int          n_fail;
    int          cyc;
    int          last_resp;

    data_sram_responder #(.ADDR_W(10), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst),
        .data_sram_en(en[0]), .data_sram_wen(wen_s[0]),
        .data_sram_addr(addr_s[0]), .data_sram_wdata(wdata_s[0]),
        .data_sram_rdata(rdata_s[0]), .data_sram_rvalid(rvalid_s[0]),
        .data_sram_stall(stall_s[0])
    );

    data_sram_responder #(.ADDR_W(10), .LATENCY(3)) dut3 (
        .clk(clk), .rst(rst),
        .data_sram_en(en[1]), .data_sram_wen(wen_s[1]),
        .data_sram_addr(addr_s[1]), .data_sram_wdata(wdata_s[1]),
        .data_sram_rdata(rdata_s[1]), .data_sram_rvalid(rvalid_s[1]),
        .data_sram_stall(stall_s[1])
    );

    data_sram_responder #(.ADDR_W(10), .LATENCY(4)) dut4 (
        .clk(clk), .rst(rst),
        .data_sram_en(en[2]), .data_sram_wen(wen_s[2]),
        .data_sram_addr(addr_s[2]), .data_sram_wdata(wdata_s[2]),
        .data_sram_rdata(rdata_s[2]), .data_sram_rvalid(rvalid_s[2]),
        .data_sram_stall(stall_s[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic int lat_of(input int k);
        case (k)
            0: return 1;
            1: return 3;
            default: return 4;
        endcase
    endfunction

    task automatic do_req(
        input string       name,
        input int          k,
        input logic [3:0]  wen,
        input logic [31:0] addr,
        input logic [31:0] wdata,
        input int          hold
    );
        int          idx;
        int          lat;
        int          nst;
        logic [31:0] exp;
        idx = int'(addr[11:2]);
        @(negedge clk);
        en[k]      = 1'b1;
        wen_s[k]   = wen;
        addr_s[k]  = addr;
        wdata_s[k] = wdata;
        for (int i = 0; i < 4; i++) begin
            if (wen[i]) model[k][idx][8*i +: 8] = wdata[8*i +: 8];
        end
        sb.push_back(model[k][idx]);
        lat = -1;
        nst = 0;
        for (int c = 0; c <= 20; c++) begin
            #1;
            if (rvalid_s[k] === 1'b1) begin
                lat = c;
                break;
            end
            if (stall_s[k] === 1'b1) nst++;
            @(negedge clk);
            if (c + 1 >= hold) en[k] = 1'b0;
        end
        last_resp = cyc;
        n_checks++;
        if (lat < 0) begin
            n_fail++;
            $display("FAIL %s timeout: no rvalid within 20 cycles", name);
            exp = sb.pop_front();
        end else begin
            exp = sb.pop_front();
            if (rdata_s[k] !== exp) begin
                n_fail++;
                $display("FAIL %s rdata: got %h expected %h",
                         name, rdata_s[k], exp);
            end
            n_checks++;
            if (stall_s[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL %s stall in resp: got %b expected 0",
                         name, stall_s[k]);
            end
        end
        n_checks++;
        if (lat !== lat_of(k)) begin
            n_fail++;
            $display("FAIL %s latency: got %0d expected %0d",
                     name, lat, lat_of(k));
        end
        n_checks++;
        if (nst !== lat_of(k)) begin
            n_fail++;
            $display("FAIL %s stall cycles: got %0d expected %0d",
                     name, nst, lat_of(k));
        end
    endtask

    task automatic idle_all();
        @(negedge clk);
        for (int k = 0; k < 3; k++) en[k] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (rvalid_s[k] !== 1'b0 || stall_s[k] !== 1'b0 ||
                rdata_s[k] !== 32'd0) begin
                n_fail++;
                $display("FAIL reset[%0d]: rvalid=%b stall=%b rdata=%h expected 0 0 0",
                         k, rvalid_s[k], stall_s[k], rdata_s[k]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_lat1_basic();
        do_req("lat1_write", 0, 4'hF, 32'h10, 32'hDEADBEEF, 100);
        idle_all();
        do_req("lat1_read", 0, 4'h0, 32'h10, 32'h0, 100);
        idle_all();
    endtask

    task automatic test_byte_lanes();
        do_req("lanes_preload", 0, 4'hF, 32'h20, 32'h11223344, 100);
        idle_all();
        do_req("lanes_write", 0, 4'b0100, 32'h20, 32'h00AA0000, 100);
        n_checks++;
        if (rdata_s[0] !== 32'h11AA3344) begin
            n_fail++;
            $display("FAIL lanes_const: got %h expected 11aa3344", rdata_s[0]);
        end
        idle_all();
        do_req("lanes_read", 0, 4'h0, 32'h20, 32'h0, 100);
        idle_all();
    endtask

    task automatic test_latency4();
        do_req("lat4_write", 2, 4'hF, 32'h18, 32'hA5A5_0F0F, 100);
        idle_all();
        do_req("lat4_read", 2, 4'h0, 32'h18, 32'h0, 100);
        idle_all();
        #1;
        n_checks++;
        if (stall_s[2] !== 1'b0 || rvalid_s[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL lat4_idle_after: stall=%b rvalid=%b expected 0 0",
                     stall_s[2], rvalid_s[2]);
        end
    endtask

    task automatic test_en_drop();
        do_req("endrop_write", 1, 4'hF, 32'h30, 32'h0BADF00D, 1);
        idle_all();
        do_req("endrop_read", 1, 4'h0, 32'h30, 32'h0, 100);
        idle_all();
    endtask

    task automatic test_reset_busy();
        @(negedge clk);
        en[1]      = 1'b1;
        wen_s[1]   = 4'hF;
        addr_s[1]  = 32'h40;
        wdata_s[1] = 32'h55555555;
        model[1][16] = 32'h55555555;
        @(negedge clk);
        en[1] = 1'b0;
        #1;
        n_checks++;
        if (stall_s[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL rstbusy_stall_before: got %b expected 1", stall_s[1]);
        end
        rst = 1'b1;
        @(negedge clk);
        #1;
        n_checks++;
        if (rvalid_s[1] !== 1'b0 || rdata_s[1] !== 32'd0 ||
            stall_s[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL rstbusy_abort: rvalid=%b rdata=%h stall=%b expected 0 0 0",
                     rvalid_s[1], rdata_s[1], stall_s[1]);
        end
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (rvalid_s[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL rstbusy_no_resp: rvalid=%b expected 0", rvalid_s[1]);
            end
        end
        do_req("rstbusy_read", 1, 4'h0, 32'h40, 32'h0, 100);
        idle_all();
    endtask

    task automatic test_alias();
        do_req("alias_write", 0, 4'hF, 32'h00001004, 32'hCAFEF00D, 100);
        idle_all();
        do_req("alias_read", 0, 4'h0, 32'h00000004, 32'h0, 100);
        idle_all();
    endtask

    task automatic test_rst_en_same();
        do_req("rsten_pre", 0, 4'hF, 32'h50, 32'h12345678, 100);
        idle_all();
        @(negedge clk);
        rst        = 1'b1;
        en[0]      = 1'b1;
        wen_s[0]   = 4'hF;
        addr_s[0]  = 32'h50;
        wdata_s[0] = 32'hFFFFFFFF;
        @(negedge clk);
        rst   = 1'b0;
        en[0] = 1'b0;
        do_req("rsten_read", 0, 4'h0, 32'h50, 32'h0, 100);
        idle_all();
    endtask

    task automatic test_back_to_back();
        int t1;
        do_req("b2b_first", 2, 4'hF, 32'h60, 32'h01020304, 100);
        t1 = last_resp;
        do_req("b2b_second", 2, 4'b0011, 32'h60, 32'h0000BEEF, 100);
        n_checks++;
        if (last_resp - t1 !== lat_of(2) + 1) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d expected %0d",
                     last_resp - t1, lat_of(2) + 1);
        end
        idle_all();
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        cyc       = 0;
        last_resp = 0;
        rst       = 1'b1;
        for (int k = 0; k < 3; k++) begin
            en[k]      = 1'b0;
            wen_s[k]   = 4'h0;
            addr_s[k]  = 32'h0;
            wdata_s[k] = 32'h0;
        end
        test_reset();
        test_lat1_basic();
        test_byte_lanes();
        test_latency4();
        test_en_drop();
        test_reset_busy();
        test_alias();
        test_rst_en_same();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
